da_bitslice_feeder: RTL and testbench

//  Transmit side of the DA complex vector multiplier's input interface: accepts one complex
//  N-element sample vector per valid/ready handshake and emits it LSB-first as bit-slice LUT addresses.

---
 rtl/da_bitslice_feeder_pkg.sv | 24 ++
 rtl/da_bitslice_feeder_vec_hold.sv | 31 +++
 rtl/da_bitslice_feeder.sv | 166 ++++++++++++++++
 tb/tb_da_bitslice_feeder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/da_bitslice_feeder_pkg.sv
// Shared types and the bit-slice extraction helper for the DA input feeder.
package da_pkg;

  localparam int unsigned DA_W = 8;
  localparam int unsigned DA_N = 4;

  typedef enum logic [1:0] {
    IDLE,
    PASS0,
    PASS1
  } feed_state_e;

  // Bit idx of every element; element 0 lands on the MSB of the LUT address.
  function automatic logic [DA_N-1:0] slice_of(input logic [DA_N*DA_W-1:0] vec,
                                               input int unsigned idx);
    logic [DA_N-1:0] s;
    s = '0;
    for (int unsigned k = 0; k < DA_N; k++) begin
      s[DA_N-1-k] = vec[k*DA_W+idx];
    end
    return s;
  endfunction

endpackage

// File: rtl/da_bitslice_feeder_vec_hold.sv
// Loadable holding register for one complex N-element vector (real and imaginary parts).
module da_vec_hold #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [N*W-1:0] xr_i,
  input  logic [N*W-1:0] xi_i,
  output logic [N*W-1:0] xr_o,
  output logic [N*W-1:0] xi_o
);

  logic [N*W-1:0] xr_q;
  logic [N*W-1:0] xi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr_q <= '0;
      xi_q <= '0;
    end else if (load_i) begin
      xr_q <= xr_i;
      xi_q <= xi_i;
    end
  end

  assign xr_o = xr_q;
  assign xi_o = xi_q;

endmodule

// File: rtl/da_bitslice_feeder.sv
// Bit-slice feeder for the DA complex multiplier: two LSB-first passes per accepted vector.
// Define DA_FEED_DBLBUF_EN to add a pending-vector register for bubble-free streaming.
module da_bitslice_feeder
  import da_pkg::*;
#(
  parameter int unsigned W = DA_W,
  parameter int unsigned N = DA_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [N*W-1:0]       s_xr,
  input  logic [N*W-1:0]       s_xi,
  output logic                 slice_valid,
  output logic [N-1:0]         slice_a,
  output logic [N-1:0]         slice_b,
  output logic [$clog2(W)-1:0] bit_idx,
  output logic                 sub,
  output logic                 pass,
  output logic                 vec_last
);

  localparam int unsigned CW = $clog2(W);

  feed_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accept;
  logic           cnt_end;
  logic           act_load;
  logic [N*W-1:0] act_xr_in, act_xi_in;
  logic [N*W-1:0] act_xr, act_xi;

  assign cnt_end = (cnt_q == CW'(W-1));
  assign accept  = s_valid && s_ready;

`ifdef DA_FEED_DBLBUF_EN
  logic           pend_full_q, pend_full_d;
  logic           pend_load;
  logic           promote;
  logic [N*W-1:0] pend_xr, pend_xi;

  assign s_ready = !pend_full_q;

  da_vec_hold #(.W(W), .N(N)) u_pend (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pend_load),
    .xr_i   (s_xr),
    .xi_i   (s_xi),
    .xr_o   (pend_xr),
    .xi_o   (pend_xi)
  );

  assign act_xr_in = promote ? pend_xr : s_xr;
  assign act_xi_in = promote ? pend_xi : s_xi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_full_q <= 1'b0;
    else        pend_full_q <= pend_full_d;
  end
`else
  assign s_ready   = (state_q == IDLE);
  assign act_xr_in = s_xr;
  assign act_xi_in = s_xi;
`endif

  da_vec_hold #(.W(W), .N(N)) u_act (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (act_load),
    .xr_i   (act_xr_in),
    .xi_i   (act_xi_in),
    .xr_o   (act_xr),
    .xi_o   (act_xi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_load = 1'b0;
`ifdef DA_FEED_DBLBUF_EN
    pend_full_d = pend_full_q;
    pend_load   = 1'b0;
    promote     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          act_load = 1'b1;
          state_d  = PASS0;
          cnt_d    = '0;
        end
      end
      PASS0: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_end) begin
          state_d = PASS1;
          cnt_d   = '0;
        end
`ifdef DA_FEED_DBLBUF_EN
        if (accept) begin
          pend_load   = 1'b1;
          pend_full_d = 1'b1;
        end
`endif
      end
      PASS1: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_end) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef DA_FEED_DBLBUF_EN
          // A vector arriving on the final edge with an empty pending slot goes straight to active.
          if (pend_full_q) begin
            promote     = 1'b1;
            act_load    = 1'b1;
            pend_full_d = 1'b0;
            state_d     = PASS0;
          end else if (accept) begin
            act_load = 1'b1;
            state_d  = PASS0;
          end
        end else if (accept) begin
          pend_load   = 1'b1;
          pend_full_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    slice_valid = 1'b0;
    slice_a     = '0;
    slice_b     = '0;
    bit_idx     = '0;
    sub         = 1'b0;
    pass        = 1'b0;
    vec_last    = 1'b0;
    if (state_q != IDLE) begin
      slice_valid = 1'b1;
      pass        = (state_q == PASS1);
      bit_idx     = cnt_q;
      sub         = cnt_end;
      vec_last    = pass && cnt_end;
      slice_a     = slice_of(pass ? act_xi : act_xr, 32'(cnt_q));
      slice_b     = slice_of(pass ? act_xr : act_xi, 32'(cnt_q));
    end
  end

endmodule

// File: tb/tb_da_bitslice_feeder.sv
// Randomized self-checking bench for da_bitslice_feeder against a slice-stream reference model.
module tb_da_bitslice_feeder;

  localparam int W = 8;
  localparam int N = 4;
`ifdef DA_FEED_DBLBUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   idx;
    logic         sub;
    logic         pas;
    logic         last;
  } exp_t;

  logic           clk, rst_n, s_valid, s_ready;
  logic [N*W-1:0] s_xr, s_xi;
  logic           slice_valid, sub, pass, vec_last;
  logic [N-1:0]   slice_a, slice_b;
  logic [2:0]     bit_idx;

  int   errs = 0;
  int   checks = 0;
  exp_t q[$];
  int   run = 0, maxrun = 0;
  bit   clr = 0;

  da_bitslice_feeder #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_xr        (s_xr),
    .s_xi        (s_xi),
    .slice_valid (slice_valid),
    .slice_a     (slice_a),
    .slice_b     (slice_b),
    .bit_idx     (bit_idx),
    .sub         (sub),
    .pass        (pass),
    .vec_last    (vec_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected stream for one vector: real pass then imag pass, each LSB first.
  task automatic push_vec(input logic [N*W-1:0] xr, input logic [N*W-1:0] xi);
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < W; b++) begin
        e = '0;
        for (int k = 0; k < N; k++) begin
          int ea, eb;
          ea = int'((p == 0 ? xr : xi) >> (k*W)) & ((1 << W) - 1);
          eb = int'((p == 0 ? xi : xr) >> (k*W)) & ((1 << W) - 1);
          e.a[N-1-k] = ((ea >> b) & 1) != 0;
          e.b[N-1-k] = ((eb >> b) & 1) != 0;
        end
        e.idx  = 3'(b);
        e.sub  = (b == W-1);
        e.pas  = (p == 1);
        e.last = (p == 1) && (b == W-1);
        q.push_back(e);
      end
    end
  endtask

  logic [13:0] obs;
  assign obs = {slice_a, slice_b, bit_idx, sub, pass, vec_last};

  always @(negedge clk) begin
    bit rdy_exp;
    if (!rst_n) begin
      q.delete();
      chk("rst_valid", slice_valid, 0);
      chk("rst_ready", s_ready, 1);
      chk("rst_outs", obs, 0);
    end else begin
      rdy_exp = DBL ? (q.size() <= 2*W) : (q.size() == 0);
      chk("valid", slice_valid, q.size() != 0);
      chk("ready", s_ready, rdy_exp);
      if (slice_valid && q.size() != 0) chk("slice", obs, q.pop_front());
      else if (!slice_valid)            chk("idle_zero", obs, 0);
      if (s_valid && rdy_exp) push_vec(s_xr, s_xi);
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      run = 0;
      maxrun = 0;
    end else begin
      run = slice_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
  end

  task automatic send(input logic [N*W-1:0] xr, input logic [N*W-1:0] xi, input bit scr);
    bit ok;
    ok = 0;
    s_valid = 1'b1;
    s_xr = xr;
    s_xi = xi;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        break;
      end
      if (scr) begin
        s_xr = {$urandom, $urandom};
        s_xi = {$urandom, $urandom};
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_xr = {$urandom, $urandom};
    s_xi = {$urandom, $urandom};
    chk("send_timeout", ok, 1);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_xr = '0;
    s_xi = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    @(posedge clk); #1;
    send(32'h0000_0081, 32'h0200_0000, 0);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    send('1, '1, 0);
    repeat (20) @(negedge clk);

    clr = 1;
    @(negedge clk);
    #1 clr = 0;
    @(posedge clk); #1;
    send(32'h1234_5678, 32'h9ABC_DEF0, 0);
    send(32'h8001_7F80, 32'h00FF_55AA, 0);
    repeat (45) @(negedge clk);
    chk("run_len", maxrun, DBL ? 32 : 16);

    @(posedge clk); #1;
    send({$urandom, $urandom}, {$urandom, $urandom}, 1);
    send({$urandom, $urandom}, {$urandom, $urandom}, 1);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (slice_valid && pass && bit_idx == 3'd3) begin
        found = 1;
        break;
      end
    end
    chk("wait_pass1_idx3", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", slice_valid, 0);
    chk("async_outs", obs, 0);
    chk("async_ready", s_ready, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    send(32'h7F80_01FE, 32'hC3A5_5A3C, 0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      s_valid = ($urandom % 3) != 0;
      s_xr = {$urandom, $urandom};
      s_xi = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
